// File: rtl/sniffer_pkg.sv
// sniffer_pkg: shared byte/pattern types, default sizes and window-depth helper for the string matcher.
package sniffer_pkg;
   localparam int P_BYTES_PER_WORD = 4;
   localparam int P_MAX_LEN        = 17;
   localparam int P_NUM_PATTERNS   = 4;
   localparam int P_OFFSET_W       = 16;
   typedef logic [7:0] byte_t;
   typedef struct packed {
      logic [$clog2(P_MAX_LEN+1)-1:0] len;
      byte_t [P_MAX_LEN-1:0]          bytes;
   } pattern_t;
   function automatic int win_words(input int max_len, input int bpw);
      return (max_len + 2*bpw - 2) / bpw;
   endfunction
endpackage

// File: rtl/pattern_lane.sv
// pattern_lane: compares one pattern slot against the byte window at every end-alignment of the newest word.
module pattern_lane
   import sniffer_pkg::*;
#(
   parameter int BYTES_PER_WORD = P_BYTES_PER_WORD,
   parameter int MAX_LEN        = P_MAX_LEN,
   parameter int WIN_BYTES      = 20,
   parameter int FILL_W         = 5,
   parameter int ALIGN_W        = 2
) (
   input  pattern_t              i_pat,
   input  byte_t [WIN_BYTES-1:0] i_win,
   input  logic [FILL_W-1:0]     i_fill,
   output logic                  o_hit,
   output logic [ALIGN_W-1:0]    o_align
);
   int   w_len;
   logic w_ok;
   always_comb begin
      w_len   = int'(i_pat.len);
      o_hit   = 1'b0;
      o_align = '0;
      w_ok    = 1'b0;
      // Window byte 0 is the newest; a higher alignment ends earlier, so the last hit found wins.
      for (int a = 0; a < BYTES_PER_WORD; a++) begin
         w_ok = w_len != 0 && w_len <= MAX_LEN && a + w_len <= int'(i_fill);
         for (int k = 0; k < MAX_LEN; k++)
            if (w_ok && k < w_len && i_win[a+k] != i_pat.bytes[MAX_LEN-w_len+k]) w_ok = 1'b0;
         if (w_ok) begin
            o_hit   = 1'b1;
            o_align = ALIGN_W'(a);
         end
      end
   end
endmodule

// File: rtl/multi_string_matcher.sv
// multi_string_matcher: scans a word stream for runtime-programmed strings, reporting sticky hits,
// the first hit and its end offset, while passing the stream through with fixed latency.
module multi_string_matcher
   import sniffer_pkg::*;
#(
   parameter int BYTES_PER_WORD = P_BYTES_PER_WORD,
   parameter int MAX_LEN        = P_MAX_LEN,
   parameter int NUM_PATTERNS   = P_NUM_PATTERNS,
   parameter int OFFSET_W       = P_OFFSET_W
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic                            clear,
   input  logic                            data_valid,
   input  logic [8*BYTES_PER_WORD-1:0]     data_in,
   input  logic                            cfg_we,
   input  logic [$clog2(NUM_PATTERNS)-1:0] cfg_idx,
   input  logic [$clog2(MAX_LEN+1)-1:0]    cfg_len,
   input  logic [8*MAX_LEN-1:0]            cfg_pattern,
   output logic                            match,
   output logic [NUM_PATTERNS-1:0]         match_vec,
   output logic                            match_pulse,
   output logic [$clog2(NUM_PATTERNS)-1:0] first_match_id,
   output logic [OFFSET_W-1:0]             first_match_end,
   output logic [8*BYTES_PER_WORD-1:0]     data_out,
   output logic                            data_out_valid
);
   localparam int WIN_WORDS = win_words(MAX_LEN, BYTES_PER_WORD);
   localparam int WIN_BYTES = WIN_WORDS * BYTES_PER_WORD;
   localparam int FILL_W    = $clog2(WIN_BYTES + 1);
   localparam int ALIGN_W   = $clog2(BYTES_PER_WORD);
   localparam int ID_W      = $clog2(NUM_PATTERNS);

   byte_t [WIN_BYTES-1:0]   r_win;
   logic [FILL_W-1:0]       r_fill;
   logic [OFFSET_W-1:0]     r_cnt;
   logic                    r_new;
   pattern_t                r_cfg [NUM_PATTERNS];
   logic [NUM_PATTERNS-1:0] w_lane_hit, w_hit;
   logic [ALIGN_W-1:0]      w_align [NUM_PATTERNS];
   logic [ID_W-1:0]         w_id;
   logic [OFFSET_W-1:0]     w_end;
   logic [OFFSET_W:0]       w_cnt_sum;

   for (genvar g = 0; g < NUM_PATTERNS; g++) begin : g_lane
      pattern_lane #(
         .BYTES_PER_WORD(BYTES_PER_WORD), .MAX_LEN(MAX_LEN), .WIN_BYTES(WIN_BYTES),
         .FILL_W(FILL_W), .ALIGN_W(ALIGN_W)
      ) u_lane (
         .i_pat(r_cfg[g]), .i_win(r_win), .i_fill(r_fill),
         .o_hit(w_lane_hit[g]), .o_align(w_align[g])
      );
   end

   // Only a word that just entered the window is compared, so idle cycles never re-hit.
   assign w_hit     = r_new ? w_lane_hit : '0;
   assign w_cnt_sum = {1'b0, r_cnt} + (OFFSET_W+1)'(BYTES_PER_WORD);
   assign w_end     = &r_cnt ? '1 : r_cnt - OFFSET_W'(w_align[w_id]);

   always_comb begin
      w_id = '0;
      for (int p = NUM_PATTERNS - 1; p >= 0; p--)
         if (w_hit[p]) w_id = ID_W'(p);
   end

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst)
         for (int p = 0; p < NUM_PATTERNS; p++) r_cfg[p] <= '0;
      else if (cfg_we)
         r_cfg[cfg_idx] <= {cfg_len, cfg_pattern};

   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         r_win           <= '0;
         r_fill          <= '0;
         r_cnt           <= '0;
         r_new           <= 1'b0;
         match           <= 1'b0;
         match_vec       <= '0;
         match_pulse     <= 1'b0;
         first_match_id  <= '0;
         first_match_end <= '0;
         data_out        <= '0;
         data_out_valid  <= 1'b0;
      end else if (clear) begin
         r_win           <= '0;
         r_fill          <= '0;
         r_cnt           <= '0;
         r_new           <= 1'b0;
         match           <= 1'b0;
         match_vec       <= '0;
         match_pulse     <= 1'b0;
         first_match_id  <= '0;
         first_match_end <= '0;
         data_out        <= '0;
         data_out_valid  <= 1'b0;
      end else begin
         r_new          <= data_valid;
         data_out_valid <= data_valid && r_fill == FILL_W'(WIN_BYTES);
         if (data_valid) begin
            r_win    <= {r_win[WIN_BYTES-BYTES_PER_WORD-1:0], data_in};
            r_fill   <= (r_fill >= FILL_W'(WIN_BYTES - BYTES_PER_WORD)) ? FILL_W'(WIN_BYTES)
                                                                       : r_fill + FILL_W'(BYTES_PER_WORD);
            r_cnt    <= w_cnt_sum[OFFSET_W] ? '1 : w_cnt_sum[OFFSET_W-1:0];
            data_out <= r_win[WIN_BYTES-1 -: BYTES_PER_WORD];
         end
         match_vec   <= match_vec | w_hit;
         match       <= |(match_vec | w_hit);
         match_pulse <= !match && |w_hit;
         if (!match && |w_hit) begin
            first_match_id  <= w_id;
            first_match_end <= w_end;
         end
      end
endmodule

// File: tb/tb_multi_string_matcher.sv
// tb_multi_string_matcher: directed scenarios plus randomized traffic checked against a byte-stream model.
module tb_multi_string_matcher;
   logic         clk = 0, n_rst = 0, clear = 0, data_valid = 0, cfg_we = 0;
   logic [31:0]  data_in = 0;
   logic [1:0]   cfg_idx = 0;
   logic [4:0]   cfg_len = 0;
   logic [135:0] cfg_pattern = 0;
   logic         match, match_pulse, data_out_valid;
   logic [3:0]   match_vec;
   logic [1:0]   first_match_id;
   logic [15:0]  first_match_end;
   logic [31:0]  data_out;
   int           n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   multi_string_matcher dut (
      .clk(clk), .n_rst(n_rst), .clear(clear), .data_valid(data_valid), .data_in(data_in),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
      .match(match), .match_vec(match_vec), .match_pulse(match_pulse),
      .first_match_id(first_match_id), .first_match_end(first_match_end),
      .data_out(data_out), .data_out_valid(data_out_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the packet is a list of bytes; a slot hits at 1-based end position e
   // when the last len bytes up to e equal the pattern.
   logic [7:0]  m_pat [4][17];
   int          m_len [4] = '{default: 0};
   logic [7:0]  m_str [$];
   logic [31:0] m_words [$];
   bit          m_new = 0;
   int          m_n = 0;
   logic [3:0]  e_vec = 0;
   bit          e_match = 0, e_pulse = 0, e_dov = 0;
   logic [1:0]  e_id = 0;
   logic [15:0] e_end = 0;
   logic [31:0] e_dout = 0;

   function automatic bit slot_hit(input int p, input int e);
      if (m_len[p] < 1 || m_len[p] > 17 || e < m_len[p]) return 0;
      for (int j = 0; j < m_len[p]; j++)
         if (m_str[e - m_len[p] + j] !== m_pat[p][j]) return 0;
      return 1;
   endfunction

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int p = 0; p < 4; p++) m_len[p] = 0;
         m_str.delete(); m_words.delete();
         m_new = 0; e_vec = 0; e_match = 0; e_pulse = 0; e_dov = 0; e_id = 0; e_end = 0; e_dout = 0;
      end else begin
         if (clear) begin
            m_str.delete(); m_words.delete();
            m_new = 0; e_vec = 0; e_match = 0; e_pulse = 0; e_dov = 0; e_id = 0; e_end = 0; e_dout = 0;
         end else begin
            e_pulse = 0;
            if (m_new) begin
               m_n = m_str.size();
               for (int p = 0; p < 4; p++)
                  for (int e = m_n - 3; e <= m_n; e++)
                     if (slot_hit(p, e)) begin
                        if (!e_match && !e_pulse) begin
                           e_pulse = 1; e_id = p[1:0]; e_end = e[15:0];
                        end
                        e_vec[p] = 1;
                        break;
                     end
               e_match = |e_vec;
            end
            if (data_valid) begin
               e_dov = m_words.size() == 5;
               if (e_dov) e_dout = m_words.pop_front();
               m_words.push_back(data_in);
               for (int b = 3; b >= 0; b--) m_str.push_back(data_in[8*b +: 8]);
               m_new = 1;
            end else begin
               e_dov = 0;
               m_new = 0;
            end
         end
         if (cfg_we) begin
            m_len[cfg_idx] = int'(cfg_len);
            for (int j = 0; j < 17; j++) m_pat[cfg_idx][j] = cfg_pattern[135 - 8*j -: 8];
         end
      end
   end

   always @(negedge clk)
      if (n_rst) begin
         chk("match", match, e_match);
         chk("match_vec", match_vec, e_vec);
         chk("match_pulse", match_pulse, e_pulse);
         chk("first_match_id", first_match_id, e_id);
         chk("first_match_end", first_match_end, e_end);
         chk("data_out_valid", data_out_valid, e_dov);
         if (e_dov) chk("data_out", data_out, e_dout);
      end

   task automatic cyc(input bit v, input logic [31:0] d, input bit c = 0);
      data_valid = v; data_in = d; clear = c;
      @(posedge clk); @(negedge clk);
      data_valid = 0; clear = 0; cfg_we = 0;
   endtask

   task automatic prog(input int idx, input int len, input logic [135:0] pat);
      cfg_we = 1; cfg_idx = idx[1:0]; cfg_len = len[4:0]; cfg_pattern = pat;
      cyc(0, 0);
   endtask

   function automatic logic [135:0] str2pat(input string s);
      logic [135:0] r;
      r = 0;
      for (int i = 0; i < s.len(); i++) r[135 - 8*i -: 8] = s[i];
      return r;
   endfunction

   function automatic logic [7:0] rb();
      logic [7:0] r;
      r = 8'($urandom_range(0, 2));
      return r == 0 ? 8'h00 : 8'h40 + r;
   endfunction

   logic [7:0]   pb [17];
   logic [31:0]  w5 [5];
   logic [31:0]  tw [12];
   logic [135:0] lp;

   initial begin
      repeat (2) @(negedge clk);
      n_rst = 1;
      chk("rst_vec", match_vec, 0);
      chk("rst_dov", data_out_valid, 0);
      // single-word hit
      prog(0, 4, str2pat("GET "));
      cyc(0, 0, 1);
      cyc(1, 32'h47455420);
      chk("t1_before", match, 0);
      cyc(0, 0);
      chk("t1_vec", match_vec, 4'b0001);
      chk("t1_pulse", match_pulse, 1);
      chk("t1_end", first_match_end, 4);
      cyc(0, 0);
      chk("t1_pulse_off", match_pulse, 0);
      chk("t1_sticky", match_vec, 4'b0001);
      // hit spanning three words
      prog(1, 8, str2pat("HTTP/1.1"));
      cyc(0, 0, 1);
      cyc(1, 32'h00004854); cyc(1, 32'h54502F31); cyc(1, 32'h2E310000);
      cyc(0, 0);
      chk("t2_vec", match_vec, 4'b0010);
      chk("t2_id", first_match_id, 1);
      chk("t2_end", first_match_end, 10);
      // zero pattern must not hit flushed window bytes
      prog(2, 4, 0);
      cyc(0, 0, 1);
      repeat (3) cyc(0, 0);
      chk("t3_idle", match, 0);
      cyc(1, 0);
      cyc(0, 0);
      chk("t3_vec", match_vec, 4'b0100);
      chk("t3_end", first_match_end, 4);
      // simultaneous hits, lowest slot wins, later hit keeps first_*
      prog(3, 3, str2pat("ET "));
      cyc(0, 0, 1);
      cyc(1, 32'h47455420);
      cyc(0, 0);
      chk("t4_vec", match_vec, 4'b1001);
      chk("t4_id", first_match_id, 0);
      cyc(1, 32'h48545450); cyc(1, 32'h2F312E31);
      cyc(0, 0);
      chk("t4_vec2", match_vec, 4'b1011);
      chk("t4_id2", first_match_id, 0);
      chk("t4_end2", first_match_end, 4);
      // 17-byte pattern at offset 3, then a mid-packet clear
      lp = 0;
      for (int i = 0; i < 17; i++) begin
         pb[i] = 8'($urandom_range(128, 255));
         lp[135 - 8*i -: 8] = pb[i];
      end
      w5[0] = {24'h111111, pb[0]};
      for (int k = 1; k < 5; k++) w5[k] = {pb[4*k-3], pb[4*k-2], pb[4*k-1], pb[4*k]};
      prog(3, 17, lp);
      cyc(0, 0, 1);
      for (int k = 0; k < 5; k++) cyc(1, w5[k]);
      cyc(0, 0);
      chk("t5_vec", match_vec, 4'b1000);
      chk("t5_id", first_match_id, 3);
      chk("t5_end", first_match_end, 20);
      cyc(0, 0, 1);
      for (int k = 0; k < 3; k++) cyc(1, w5[k]);
      cyc(1, w5[3], 1);
      chk("t5_clr_match", match, 0);
      chk("t5_clr_dov", data_out_valid, 0);
      cyc(1, w5[4]);
      cyc(0, 0);
      chk("t5_nohit", match, 0);
      cyc(1, 32'h47455420);
      cyc(0, 0);
      chk("t5_cnt_end", first_match_end, 8);
      // gapped pass-through, then asynchronous reset mid-stream
      cyc(0, 0, 1);
      for (int i = 0; i < 12; i++) tw[i] = $urandom;
      tw[7] = 32'h47455420;
      for (int i = 0; i < 10; i++) begin
         cyc(1, tw[i]);
         if (i == 5) begin
            chk("t6_dout", data_out, tw[0]);
            chk("t6_dov", data_out_valid, 1);
         end
         if (i < 9) cyc(0, 0);
         if (i == 5) chk("t6_gap_dov", data_out_valid, 0);
      end
      chk("t6_prematch", match, 1);
      #2 n_rst = 0;
      #1;
      chk("t6_rst_match", match, 0);
      chk("t6_rst_vec", match_vec, 0);
      chk("t6_rst_pulse", match_pulse, 0);
      chk("t6_rst_id", first_match_id, 0);
      chk("t6_rst_end", first_match_end, 0);
      chk("t6_rst_dout", data_out, 0);
      chk("t6_rst_dov", data_out_valid, 0);
      @(negedge clk);
      n_rst = 1;
      cyc(1, 32'h47455420);
      cyc(0, 0);
      chk("t6_slots_lost", match, 0);
      // randomized traffic over a tiny alphabet so hits are frequent
      for (int it = 0; it < 4000; it++) begin
         if ($urandom_range(0, 24) == 0) begin
            cfg_we = 1;
            cfg_idx = 2'($urandom_range(0, 3));
            cfg_len = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 20)) : 5'($urandom_range(1, 4));
            for (int j = 0; j < 17; j++) cfg_pattern[135 - 8*j -: 8] = rb();
         end
         cyc($urandom_range(0, 9) < 7, {rb(), rb(), rb(), rb()}, $urandom_range(0, 59) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
